uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//   Next-generation UART transmitter: FIFO-buffered, parametrised frame width, runtime parity,
//   stop-bit count and baud divisor. Sits between the CPU's MMIO store path and the TX pin.
//   Accepts characters on a valid/ready port and serialises them back-to-back, LSB first.
// PARAMETERS
//   CLK_FREQ    48_000_000  system clock frequency, Hz
//   BAUD_RATE   115_200     default baud; DEF_DIV = CLK_FREQ/BAUD_RATE clocks per bit
//   DATA_BITS   8           payload bits per frame, legal 5..9
//   FIFO_DEPTH  16          TX FIFO entries, power of two, >= 2
// PORTS
//   clk         in   1             system clock, all logic on rising edge
//   rst_n       in   1             asynchronous active-low reset
//   wr_valid    in   1             producer presents a character
//   wr_data     in   DATA_BITS     character payload
//   wr_ready    out  1             FIFO can accept; push occurs when wr_valid & wr_ready
//   baud_div    in   16            clocks per bit minus 1; 0 selects DEF_DIV
//   cfg_par_en  in   1             1 = parity bit appended after data
//   cfg_par_odd in   1             1 = odd parity, 0 = even
//   cfg_stop2   in   1             1 = two stop bits, 0 = one
//   tx          out  1             serial line, idles high
//   tx_busy     out  1             frame in progress
//   tx_done     out  1             one-cycle pulse in last cycle of final stop bit
//   fifo_level  out  $clog2(FIFO_DEPTH)+1   entries currently queued (excludes frame on line)
// BEHAVIOUR
//   Reset (async): tx=1, tx_busy=0, tx_done=0, fifo_level=0, wr_ready=1, FSM=IDLE, FIFO empty.
//   Reset mid-frame aborts immediately: tx returns high same edge, queued data discarded.
//   FIFO: wr_ready = (fifo_level != FIFO_DEPTH), combinational from level; no push when full
//     even if a pop occurs the same cycle. Push and pop same cycle when not full: level unchanged.
//   FSM states IDLE, START, DATA, PARITY, STOP.
//     IDLE: if FIFO non-empty, pop head; latch data, baud_div, cfg_* into frame registers;
//       -> START next cycle. Config/divisor changes mid-frame have no effect until next pop.
//     START: tx=0 for one bit period -> DATA.
//     DATA: tx=data[bit_idx], bit_idx 0..DATA_BITS-1, LSB first -> PARITY if par_en else STOP.
//     PARITY: tx = ^data ^ par_odd (even parity -> XOR of data bits) -> STOP.
//     STOP: tx=1 for 1 or 2 bit periods; tx_done pulses in final cycle; then if FIFO
//       non-empty pop in that same cycle and enter START next cycle (zero idle gap), else IDLE.
//   Bit period P = (latched div==0) ? DEF_DIV : div+1 clocks; every bit lasts exactly P cycles.
//   Latency: push into empty FIFO with FSM IDLE -> pop next cycle -> tx falls the cycle after
//     (start bit begins 2 cycles after accepting edge).
//   tx_busy = 1 in START/DATA/PARITY/STOP; 0 in IDLE. tx registered, glitch-free.
//   Frame length = 1 + DATA_BITS + par_en + (1+stop2) bit periods.
//   Bit counter 16-bit, wraps to 0 at P-1; bit_idx width $clog2(DATA_BITS+1).
//   Simulation-only $display of each popped character permitted under `ifdef SIM.
// STRUCTURE
//   Shared package uart_pkg: FSM state encoding, DEF_DIV computation function,
//   parity/stop config constants (reused by the future uart_rx successor).
//   One sub-module: uart_sync_fifo (DATA_BITS wide, FIFO_DEPTH deep, level output,
//   same async active-low reset); FSM, divider and shifter live in this module.
// TESTING
//   1 Reset, baud_div=3 (P=4), 8N1, push 0xA5 -> tx: low 4 cycles, bits 1,0,1,0,0,1,0,1
//     4 cycles each, high 4 cycles; tx_done once; total 40 busy cycles.
//   2 Push 0x55,0x0F,0xF0 consecutively -> three frames with no idle cycle between stop and
//     next start; fifo_level 0->1->2->... then drains to 0; 3 tx_done pulses.
//   3 cfg_par_en=1: 0x07 even -> parity 1; odd -> parity 0; cfg_stop2=1 -> stop high 8 cycles.
//   4 Fill 16 entries while a frame runs -> wr_ready=0 at level 16, 17th push refused;
//     data order on line matches push order, no loss or duplicate.
//   5 DATA_BITS=5 build, push 0x1F -> 5 data bits only; baud_div=0 -> P=416 cycles.
//   6 Assert rst_n low mid-DATA -> tx=1, tx_busy=0, fifo_level=0 without waiting for clk;
//     after release, IDLE line, next push transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmitter and its receiver counterpart.
//   Contents:
//     uart_state_e    frame FSM state encoding (IDLE/START/DATA/PARITY/STOP)
//     PAR_* / STOP_*  encodings of the runtime parity and stop-bit selects
//     MAX_DATA_BITS   widest supported payload
//     calc_def_div    default clocks per bit from clock and baud rate
//     calc_parity     parity bit over a zero-padded payload
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  localparam int unsigned MAX_DATA_BITS = 9;

  // Clocks per bit used when the runtime divisor is zero.
  function automatic int unsigned calc_def_div(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Even parity is the XOR of the data bits; odd parity inverts it.
  // Unused upper bits of the payload must be zero.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock FIFO holding characters waiting for transmission.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset (empties the FIFO)
//     i_push, i_wdata  write request and data; ignored while full
//     i_pop            read request; ignored while empty
//     o_rdata          head entry (valid while not empty)
//     o_level          number of stored entries, 0..DEPTH
//     o_full, o_empty  level == DEPTH / level == 0
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == {LW{1'b0}});
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  // Pointer and level tracking; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
//   FIFO-buffered UART transmitter. Characters accepted on a valid/ready port
//   are serialised LSB first as start / data / optional parity / 1-2 stop bits.
//   Frames are sent back-to-back while the FIFO holds data.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     wr_valid, wr_data     producer character; pushed when wr_valid & wr_ready
//     wr_ready              FIFO not full
//     baud_div              clocks per bit minus 1 (0 selects the default divisor)
//     cfg_par_en            append parity bit
//     cfg_par_odd           1 = odd parity, 0 = even
//     cfg_stop2             1 = two stop bits
//     tx                    registered serial line, idles high
//     tx_busy               a frame is on the line
//     tx_done               one-cycle pulse in the last cycle of the final stop bit
//     fifo_level            queued characters (the frame on the line excluded)
//   Divisor and config are sampled when a character is popped, so changes only
//   take effect at the next frame.
// -----------------------------------------------------------------------------
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 48_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          wr_ready,
  input  logic [15:0]                   baud_div,
  input  logic                          cfg_par_en,
  input  logic                          cfg_par_odd,
  input  logic                          cfg_stop2,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BIW = $clog2(DATA_BITS + 1);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0]    DEF_PM1  = 16'(calc_def_div(CLK_FREQ, BAUD_RATE) - 1);
  localparam logic [BIW-1:0] LAST_IDX = BIW'(DATA_BITS - 1);

  // FIFO interface
  logic [DATA_BITS-1:0] w_fifo_rdata;
  logic [LW-1:0]        w_fifo_level;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_pop;

  // Frame state
  uart_state_e          r_state;
  uart_state_e          w_state_n;
  logic [15:0]          r_cnt;
  logic [15:0]          r_pm1;
  logic [BIW-1:0]       r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_par_en;
  logic                 r_par_odd;
  logic                 r_stop2;

  // Next values of the frame datapath
  logic [15:0]          w_cnt_n;
  logic [15:0]          w_pm1_n;
  logic [BIW-1:0]       w_bit_idx_n;
  logic                 w_stop_idx_n;
  logic [DATA_BITS-1:0] w_data_n;
  logic                 w_par_en_n;
  logic                 w_par_odd_n;
  logic                 w_stop2_n;

  // Registered outputs and their next values
  logic                     r_tx;
  logic                     r_busy;
  logic                     r_done;
  logic                     w_tx_n;
  logic                     w_busy_n;
  logic                     w_done_n;
  logic [MAX_DATA_BITS-1:0] w_par_vec;
  logic [DATA_BITS-1:0]     w_shift;

  logic w_bit_end;
  logic w_last_stop;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (wr_valid),
    .i_wdata (wr_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_level (w_fifo_level),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign wr_ready    = ~w_fifo_full;
  assign fifo_level  = w_fifo_level;
  assign tx          = r_tx;
  assign tx_busy     = r_busy;
  assign tx_done     = r_done;

  assign w_bit_end   = (r_cnt == r_pm1);
  assign w_last_stop = (r_stop_idx == r_stop2);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // FSM next state; the pop in the final stop cycle gives a zero-gap restart.
  always_comb begin
    w_state_n = r_state;
    w_pop     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_state_n = ST_START;
          w_pop     = 1'b1;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_n = ST_DATA;
        end else begin
          w_state_n = ST_START;
        end
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_idx == LAST_IDX)) begin
          if (r_par_en) begin
            w_state_n = ST_PARITY;
          end else begin
            w_state_n = ST_STOP;
          end
        end else begin
          w_state_n = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_n = ST_STOP;
        end else begin
          w_state_n = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (w_bit_end && w_last_stop) begin
          if (!w_fifo_empty) begin
            w_state_n = ST_START;
            w_pop     = 1'b1;
          end else begin
            w_state_n = ST_IDLE;
          end
        end else begin
          w_state_n = ST_STOP;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_pop     = 1'b0;
      end
    endcase
  end

  // Frame datapath next values: bit timer, bit/stop indices and latched frame.
  always_comb begin
    if (w_pop) begin
      w_data_n    = w_fifo_rdata;
      w_pm1_n     = (baud_div == 16'd0) ? DEF_PM1 : baud_div;
      w_par_en_n  = cfg_par_en;
      w_par_odd_n = cfg_par_odd;
      w_stop2_n   = cfg_stop2;
    end else begin
      w_data_n    = r_data;
      w_pm1_n     = r_pm1;
      w_par_en_n  = r_par_en;
      w_par_odd_n = r_par_odd;
      w_stop2_n   = r_stop2;
    end

    if ((r_state == ST_IDLE) || w_bit_end) begin
      w_cnt_n = 16'd0;
    end else begin
      w_cnt_n = r_cnt + 16'd1;
    end

    if (r_state != ST_DATA) begin
      w_bit_idx_n = {BIW{1'b0}};
    end else if (w_bit_end) begin
      w_bit_idx_n = r_bit_idx + BIW'(1);
    end else begin
      w_bit_idx_n = r_bit_idx;
    end

    if (w_state_n != ST_STOP) begin
      w_stop_idx_n = 1'b0;
    end else if ((r_state == ST_STOP) && w_bit_end) begin
      w_stop_idx_n = 1'b1;
    end else begin
      w_stop_idx_n = r_stop_idx;
    end
  end

  // Frame datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 16'd0;
      r_pm1      <= DEF_PM1;
      r_bit_idx  <= {BIW{1'b0}};
      r_stop_idx <= 1'b0;
      r_data     <= {DATA_BITS{1'b0}};
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_stop2    <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_n;
      r_pm1      <= w_pm1_n;
      r_bit_idx  <= w_bit_idx_n;
      r_stop_idx <= w_stop_idx_n;
      r_data     <= w_data_n;
      r_par_en   <= w_par_en_n;
      r_par_odd  <= w_par_odd_n;
      r_stop2    <= w_stop2_n;
    end
  end

  // Output decode from next state, so registered outputs line up with the state.
  always_comb begin
    w_par_vec                = {MAX_DATA_BITS{1'b0}};
    w_par_vec[DATA_BITS-1:0] = w_data_n;
    w_shift                  = w_data_n >> w_bit_idx_n;
    case (w_state_n)
      ST_IDLE:   w_tx_n = 1'b1;
      ST_START:  w_tx_n = 1'b0;
      ST_DATA:   w_tx_n = w_shift[0];
      ST_PARITY: w_tx_n = calc_parity(w_par_vec, w_par_odd_n);
      ST_STOP:   w_tx_n = 1'b1;
      default:   w_tx_n = 1'b1;
    endcase
    w_busy_n = (w_state_n != ST_IDLE);
    w_done_n = (w_state_n == ST_STOP) && (w_cnt_n == w_pm1_n) &&
               (w_stop_idx_n == w_stop2_n);
  end

  // Output registers; reset drives the line high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tx   <= w_tx_n;
      r_busy <= w_busy_n;
      r_done <= w_done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  localparam int DEF_DIV = 48_000_000 / 115_200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 8-bit instance
  logic        a_wr_valid;
  logic [7:0]  a_wr_data;
  logic        a_wr_ready;
  logic [15:0] a_div;
  logic        a_par_en, a_par_odd, a_stop2;
  logic        a_tx, a_busy, a_done;
  logic [4:0]  a_level;

  // 5-bit instance
  logic        b_wr_valid;
  logic [4:0]  b_wr_data;
  logic        b_wr_ready;
  logic [15:0] b_div;
  logic        b_par_en, b_par_odd, b_stop2;
  logic        b_tx, b_busy, b_done;
  logic [4:0]  b_level;

  uart_tx_buffered #(.DATA_BITS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(a_wr_valid), .wr_data(a_wr_data),
    .wr_ready(a_wr_ready), .baud_div(a_div), .cfg_par_en(a_par_en),
    .cfg_par_odd(a_par_odd), .cfg_stop2(a_stop2), .tx(a_tx), .tx_busy(a_busy),
    .tx_done(a_done), .fifo_level(a_level)
  );

  uart_tx_buffered #(.DATA_BITS(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(b_wr_valid), .wr_data(b_wr_data),
    .wr_ready(b_wr_ready), .baud_div(b_div), .cfg_par_en(b_par_en),
    .cfg_par_odd(b_par_odd), .cfg_stop2(b_stop2), .tx(b_tx), .tx_busy(b_busy),
    .tx_done(b_done), .fifo_level(b_level)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Per-cycle line recordings, sampled on the falling edge.
  logic qa_tx[$], qa_done[$], qa_busy[$];
  logic qb_tx[$], qb_done[$], qb_busy[$];

  always @(negedge clk) begin
    qa_tx.push_back(a_tx); qa_done.push_back(a_done); qa_busy.push_back(a_busy);
    qb_tx.push_back(b_tx); qb_done.push_back(b_done); qb_busy.push_back(b_busy);
  end

  // Expected per-cycle line, built from the frame rules.
  logic e_tx[$];
  logic e_done[$];
  int   e_flen[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int period(input logic [15:0] div);
    if (div == 16'd0) return DEF_DIV;
    else return int'(div) + 1;
  endfunction

  task automatic model_frame(input int data, input int nbits, input logic [15:0] div,
                             input bit pe, input bit po, input bit s2);
    int p;
    int ones;
    int bits[$];
    p = period(div);
    ones = 0;
    bits.push_back(0);
    for (int i = 0; i < nbits; i++) begin
      bits.push_back((data >> i) & 1);
      ones += (data >> i) & 1;
    end
    if (pe) bits.push_back((ones % 2) ^ int'(po));
    bits.push_back(1);
    if (s2) bits.push_back(1);
    for (int b = 0; b < bits.size(); b++)
      for (int c = 0; c < p; c++) begin
        e_tx.push_back(bits[b] != 0);
        e_done.push_back((b == bits.size() - 1) && (c == p - 1));
      end
    e_flen.push_back(bits.size() * p);
  endtask

  task automatic clear_all();
    qa_tx.delete(); qa_done.delete(); qa_busy.delete();
    qb_tx.delete(); qb_done.delete(); qb_busy.delete();
    e_tx.delete(); e_done.delete(); e_flen.delete();
  endtask

  function automatic int rec_size(input bit b);
    if (b) return qb_tx.size();
    else return qa_tx.size();
  endfunction

  function automatic logic rec_tx(input bit b, input int i);
    if (b) return qb_tx[i];
    else return qa_tx[i];
  endfunction

  function automatic logic rec_done(input bit b, input int i);
    if (b) return qb_done[i];
    else return qa_done[i];
  endfunction

  function automatic logic rec_busy(input bit b, input int i);
    if (b) return qb_busy[i];
    else return qa_busy[i];
  endfunction

  // Compares the recorded line against the expected frames, starting at the first low cycle.
  task automatic check_line(input string tag, input bit use_b);
    int t0;
    int scan;
    int guard;
    int total;
    int off;
    int mis_tx, mis_done, mis_busy;
    t0 = -1; scan = 0; guard = 0;
    total = e_tx.size();
    while (t0 < 0 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
      while (t0 < 0 && scan < rec_size(use_b)) begin
        if (rec_tx(use_b, scan) === 1'b0) t0 = scan;
        scan++;
      end
    end
    chk($sformatf("%s start_seen", tag), t0 >= 0, 1);
    if (t0 < 0) return;
    guard = 0;
    while (rec_size(use_b) < t0 + total + 2 && guard < total + 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk($sformatf("%s recorded", tag), rec_size(use_b) >= t0 + total + 2, 1);
    if (rec_size(use_b) < t0 + total + 2) return;
    off = 0;
    foreach (e_flen[f]) begin
      mis_tx = 0; mis_done = 0; mis_busy = 0;
      for (int c = 0; c < e_flen[f]; c++) begin
        if (rec_tx(use_b, t0 + off + c) !== e_tx[off + c]) mis_tx++;
        if (rec_done(use_b, t0 + off + c) !== e_done[off + c]) mis_done++;
        if (rec_busy(use_b, t0 + off + c) !== 1'b1) mis_busy++;
      end
      chk($sformatf("%s frame%0d tx_bad_cycles", tag, f), mis_tx, 0);
      chk($sformatf("%s frame%0d done_bad_cycles", tag, f), mis_done, 0);
      chk($sformatf("%s frame%0d busy_bad_cycles", tag, f), mis_busy, 0);
      off += e_flen[f];
    end
    chk($sformatf("%s idle_tx_after", tag), rec_tx(use_b, t0 + total), 1);
    chk($sformatf("%s idle_busy_after", tag), rec_busy(use_b, t0 + total), 0);
  endtask

  task automatic push_a(input logic [7:0] d);
    int g;
    g = 0;
    while (!a_wr_ready && g < 5000) begin @(posedge clk); #1; g++; end
    chk("push_a ready", a_wr_ready, 1);
    a_wr_valid = 1'b1; a_wr_data = d;
    @(posedge clk); #1;
    a_wr_valid = 1'b0;
  endtask

  task automatic push_b(input logic [4:0] d);
    b_wr_valid = 1'b1; b_wr_data = d;
    @(posedge clk); #1;
    b_wr_valid = 1'b0;
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #500_000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d8;
    logic [7:0] burst[17];
    int cnt;

    rst_n = 1'b0;
    a_wr_valid = 1'b0; a_wr_data = 8'h00; a_div = 16'd3;
    a_par_en = 1'b0; a_par_odd = 1'b0; a_stop2 = 1'b0;
    b_wr_valid = 1'b0; b_wr_data = 5'h00; b_div = 16'd0;
    b_par_en = 1'b0; b_par_odd = 1'b0; b_stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("reset tx", a_tx, 1);
    chk("reset busy", a_busy, 0);
    chk("reset done", a_done, 0);
    chk("reset level", a_level, 0);
    chk("reset ready", a_wr_ready, 1);
    chk("reset b_tx", b_tx, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single 8N1 frame, P=4, latency and busy length
    clear_all();
    model_frame(8'hA5, 8, 16'd3, 1'b0, 1'b0, 1'b0);
    push_a(8'hA5);
    @(negedge clk);
    chk("t1 pop_cycle tx", a_tx, 1);
    @(negedge clk);
    chk("t1 start tx", a_tx, 0);
    chk("t1 start busy", a_busy, 1);
    check_line("t1", 1'b0);
    cnt = 0;
    foreach (qa_busy[i]) if (qa_busy[i] === 1'b1) cnt++;
    chk("t1 busy_cycles", cnt, 40);
    cnt = 0;
    foreach (qa_done[i]) if (qa_done[i] === 1'b1) cnt++;
    chk("t1 done_pulses", cnt, 1);

    // 2: three queued frames back-to-back
    clear_all();
    model_frame(8'h55, 8, 16'd3, 1'b0, 1'b0, 1'b0);
    model_frame(8'h0F, 8, 16'd3, 1'b0, 1'b0, 1'b0);
    model_frame(8'hF0, 8, 16'd3, 1'b0, 1'b0, 1'b0);
    push_a(8'h55);
    chk("t2 level_after_1", a_level, 1);
    push_a(8'h0F);
    chk("t2 level_after_2", a_level, 1);   // push and pop in the same cycle
    push_a(8'hF0);
    chk("t2 level_after_3", a_level, 2);
    check_line("t2", 1'b0);
    chk("t2 level_drained", a_level, 0);
    cnt = 0;
    foreach (qa_done[i]) if (qa_done[i] === 1'b1) cnt++;
    chk("t2 done_pulses", cnt, 3);

    // 3: parity and two stop bits
    a_par_en = 1'b1; a_par_odd = 1'b0;
    clear_all();
    model_frame(8'h07, 8, 16'd3, 1'b1, 1'b0, 1'b0);
    push_a(8'h07);
    check_line("t3 even", 1'b0);
    a_par_odd = 1'b1; a_stop2 = 1'b1;
    clear_all();
    model_frame(8'h07, 8, 16'd3, 1'b1, 1'b1, 1'b1);
    push_a(8'h07);
    check_line("t3 odd_stop2", 1'b0);

    // 3b: random frames with config scrambled mid-frame
    for (int k = 0; k < 6; k++) begin
      a_div = 16'($urandom_range(1, 5));
      a_par_en = 1'($urandom); a_par_odd = 1'($urandom); a_stop2 = 1'($urandom);
      d8 = 8'($urandom_range(0, 255));
      clear_all();
      model_frame(d8, 8, a_div, a_par_en, a_par_odd, a_stop2);
      push_a(d8);
      repeat (3) @(posedge clk);
      #1;
      a_div = 16'($urandom_range(0, 7));
      a_par_en = ~a_par_en; a_par_odd = ~a_par_odd; a_stop2 = ~a_stop2;
      check_line($sformatf("t3r%0d", k), 1'b0);
    end

    // 4: fill the FIFO while a frame runs
    a_div = 16'd3; a_par_en = 1'b0; a_par_odd = 1'b0; a_stop2 = 1'b0;
    clear_all();
    for (int i = 0; i < 17; i++) begin
      burst[i] = 8'($urandom_range(0, 255));
      model_frame(burst[i], 8, 16'd3, 1'b0, 1'b0, 1'b0);
    end
    push_a(burst[0]);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i < 17; i++) push_a(burst[i]);
    chk("t4 level_full", a_level, 16);
    chk("t4 ready_low", a_wr_ready, 0);
    a_wr_valid = 1'b1; a_wr_data = ~burst[16];
    @(posedge clk); #1;
    a_wr_valid = 1'b0;
    chk("t4 refused_level", a_level, 16);
    check_line("t4", 1'b0);
    chk("t4 level_drained", a_level, 0);

    // 5: 5-bit build with default divisor
    clear_all();
    model_frame(5'h1F, 5, 16'd0, 1'b0, 1'b0, 1'b0);
    push_b(5'h1F);
    check_line("t5", 1'b1);

    // 6: asynchronous reset in the middle of a frame
    clear_all();
    push_a(8'($urandom_range(0, 255)));
    push_a(8'($urandom_range(0, 255)));
    push_a(8'($urandom_range(0, 255)));
    repeat (12) @(posedge clk);
    #1;
    chk("t6 pre busy", a_busy, 1);
    chk("t6 pre level", a_level, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 async tx", a_tx, 1);
    chk("t6 async busy", a_busy, 0);
    chk("t6 async level", a_level, 0);
    chk("t6 async ready", a_wr_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6 post tx", a_tx, 1);
    chk("t6 post busy", a_busy, 0);
    d8 = 8'($urandom_range(0, 255));
    clear_all();
    model_frame(d8, 8, 16'd3, 1'b0, 1'b0, 1'b0);
    push_a(d8);
    check_line("t6 post", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
